// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC core and its request arbiter.
//   - CORDIC_WIDTH     : default operand/result width
//   - MODE_COORD_*     : coordinate-system encodings for mode_coord
//   - MODE_OP_*        : operation encodings for mode_op
//   - arb_state_t      : arbiter FSM state encoding
// ----------------------------------------------------------------------------
package cordic_pkg;

  localparam int CORDIC_WIDTH = 32;

  // mode_coord encodings
  localparam logic [1:0] MODE_COORD_LINEAR     = 2'b00;
  localparam logic [1:0] MODE_COORD_CIRCULAR   = 2'b01;
  localparam logic [1:0] MODE_COORD_HYPERBOLIC = 2'b11;

  // mode_op encodings
  localparam logic [1:0] MODE_OP_ROTATION  = 2'b00;
  localparam logic [1:0] MODE_OP_VECTORING = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// the index after the last grant (wrapping modulo NUM_REQ) and returns the
// first set bit.
// Ports:
//   i_req   [NUM_REQ-1:0] request vector
//   i_last  [IW-1:0]      index of the previous grant
//   o_grant [NUM_REQ-1:0] one-hot grant (all zero when no request)
//   o_idx   [IW-1:0]      binary index of the grant
//   o_any   1             at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  // One extra bit so last+offset (at most 2*NUM_REQ-1) never overflows
  // before the modulo wrap.
  localparam int CW = IW + 1;

  logic [CW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    // Offset 1 first, offset NUM_REQ (the last grant itself) last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, i_last} + CW'(k);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end
      if (!o_any && i_req[w_cand[IW-1:0]]) begin
        o_any                   = 1'b1;
        o_idx                   = w_cand[IW-1:0];
        o_grant[w_cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// ----------------------------------------------------------------------------
// cordic_arbiter
// Round-robin scheduler sharing one CORDIC core among NUM_REQ requesters.
// One operation is in flight at a time: accept (IDLE) -> start pulse (ISSUE)
// -> wait for core done (WAIT) -> hand result back (RESPOND).
//
// Optional feature macro: CORDIC_ARB_TIMEOUT_EN
//   Defined    : WAIT watchdog; after TIMEOUT cycles without core_valid the
//                core is reset for one cycle and an error response is sent.
//   Undefined  : WAIT lasts until core_valid; rsp_err is constant 0.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready [NUM_REQ]    request handshake (ready is one-hot)
//   req_mode_op/req_mode_coord       2 bits per requester, slice i = [2i+1:2i]
//   req_x/req_y/req_z                WIDTH bits per requester
//   rsp_valid/rsp_ready [NUM_REQ]    response handshake (valid is one-hot)
//   rsp_x/rsp_y/rsp_z, rsp_err       shared response bus
//   core_enable, core_rst            core start pulse, core reset
//   core_mode_op/core_mode_coord     latched modes to core
//   core_x_in/core_y_in/core_z_in    latched operands to core
//   core_x_out/core_y_out/core_z_out core results
//   core_valid                       core done pulse
// ----------------------------------------------------------------------------
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = CORDIC_WIDTH,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_mode_op,
  input  logic [2*NUM_REQ-1:0]     req_mode_coord,
  input  logic [WIDTH*NUM_REQ-1:0] req_x,
  input  logic [WIDTH*NUM_REQ-1:0] req_y,
  input  logic [WIDTH*NUM_REQ-1:0] req_z,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_x,
  output logic [WIDTH-1:0]         rsp_y,
  output logic [WIDTH-1:0]         rsp_z,
  output logic                     rsp_err,
  output logic                     core_enable,
  output logic                     core_rst,
  output logic [1:0]               core_mode_op,
  output logic [1:0]               core_mode_coord,
  output logic [WIDTH-1:0]         core_x_in,
  output logic [WIDTH-1:0]         core_y_in,
  output logic [WIDTH-1:0]         core_z_in,
  input  logic [WIDTH-1:0]         core_x_out,
  input  logic [WIDTH-1:0]         core_y_out,
  input  logic [WIDTH-1:0]         core_z_out,
  input  logic                     core_valid
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         r_state;
  arb_state_t         w_state_next;

  logic [IW-1:0]      r_last_grant;
  logic [NUM_REQ-1:0] r_owner_oh;
  logic [1:0]         r_mode_op;
  logic [1:0]         r_mode_coord;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_z;
  logic [WIDTH-1:0]   r_rsp_x;
  logic [WIDTH-1:0]   r_rsp_y;
  logic [WIDTH-1:0]   r_rsp_z;

  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_grant_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_capture;
  logic               w_expire;
  logic               w_core_drive;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] r_wait_cnt;
  logic          r_rsp_err;

  // Held at zero outside WAIT, so every entry into WAIT starts from 0.
  // Saturates at TIMEOUT; the FSM leaves WAIT in that cycle anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != TW'(TIMEOUT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // A core_valid arriving in the expiry cycle takes priority.
  assign w_expire = (r_state == ST_WAIT) && (r_wait_cnt == TW'(TIMEOUT)) && !core_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (w_capture) begin
      r_rsp_err <= 1'b0;
    end else if (w_expire) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_expire = 1'b0;
  // Always false; TIMEOUT has no effect without the watchdog.
  assign rsp_err  = (TIMEOUT < 0);
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_accept     = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_valid) begin
          w_capture    = 1'b1;
          w_state_next = ST_RESPOND;
        end else if (w_expire) begin
          w_state_next = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        // Only the owner's ready completes the response.
        if (|(rsp_ready & r_owner_oh)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch and response register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= IW'(NUM_REQ - 1);
      r_owner_oh   <= '0;
      r_mode_op    <= '0;
      r_mode_coord <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_rsp_x      <= '0;
      r_rsp_y      <= '0;
      r_rsp_z      <= '0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_owner_oh   <= w_grant;
        r_mode_op    <= req_mode_op[2*w_grant_idx +: 2];
        r_mode_coord <= req_mode_coord[2*w_grant_idx +: 2];
        r_x          <= req_x[WIDTH*w_grant_idx +: WIDTH];
        r_y          <= req_y[WIDTH*w_grant_idx +: WIDTH];
        r_z          <= req_z[WIDTH*w_grant_idx +: WIDTH];
      end
      if (w_capture) begin
        r_rsp_x <= core_x_out;
        r_rsp_y <= core_y_out;
        r_rsp_z <= core_z_out;
      end else if (w_expire) begin
        r_rsp_x <= '0;
        r_rsp_y <= '0;
        r_rsp_z <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Ready is combinational from the picker; rst_n gating keeps it low while
  // reset is held even if requesters keep req_valid up.
  assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;

  assign rsp_valid = (r_state == ST_RESPOND) ? r_owner_oh : '0;
  assign rsp_x     = r_rsp_x;
  assign rsp_y     = r_rsp_y;
  assign rsp_z     = r_rsp_z;

  // The core samples operands the cycle after enable, so the latch is
  // presented for the whole ISSUE..WAIT window.
  assign w_core_drive    = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign core_enable     = (r_state == ST_ISSUE);
  assign core_rst        = !rst_n || w_expire;
  assign core_mode_op    = w_core_drive ? r_mode_op    : '0;
  assign core_mode_coord = w_core_drive ? r_mode_coord : '0;
  assign core_x_in       = w_core_drive ? r_x          : '0;
  assign core_y_in       = w_core_drive ? r_y          : '0;
  assign core_z_in       = w_core_drive ? r_z          : '0;

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;
  import cordic_pkg::*;

  localparam int NR       = 4;
  localparam int W        = 32;
  localparam int TO       = 15;
  localparam int CORE_LAT = 35;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [2*NR-1:0] req_mode_op;
  logic [2*NR-1:0] req_mode_coord;
  logic [W*NR-1:0] req_x, req_y, req_z;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready;
  logic [W-1:0]    rsp_x, rsp_y, rsp_z;
  logic            rsp_err;
  logic            core_enable, core_rst;
  logic [1:0]      core_mode_op, core_mode_coord;
  logic [W-1:0]    core_x_in, core_y_in, core_z_in;
  logic [W-1:0]    core_x_out, core_y_out, core_z_out;
  logic            core_valid;

  cordic_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_mode_op    (req_mode_op),
    .req_mode_coord (req_mode_coord),
    .req_x          (req_x),
    .req_y          (req_y),
    .req_z          (req_z),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_x          (rsp_x),
    .rsp_y          (rsp_y),
    .rsp_z          (rsp_z),
    .rsp_err        (rsp_err),
    .core_enable    (core_enable),
    .core_rst       (core_rst),
    .core_mode_op   (core_mode_op),
    .core_mode_coord(core_mode_coord),
    .core_x_in      (core_x_in),
    .core_y_in      (core_y_in),
    .core_z_in      (core_z_in),
    .core_x_out     (core_x_out),
    .core_y_out     (core_y_out),
    .core_z_out     (core_z_out),
    .core_valid     (core_valid)
  );

  always #5 clk = ~clk;

  // Core model: operands sampled one cycle after enable, result x+1/y+2/z+3
  // pulsed CORE_LAT cycles after the enable edge.
  logic         core_mute = 1'b0;
  logic         m_busy, m_valid;
  int           m_cnt;
  logic [W-1:0] m_x, m_y, m_z;
  logic         man_valid = 1'b0;
  logic [W-1:0] man_x = '0, man_y = '0, man_z = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
      m_x <= '0; m_y <= '0; m_z <= '0;
    end else if (core_rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (core_enable && !core_mute) begin
        m_busy <= 1'b1;
        m_cnt  <= CORE_LAT;
      end else if (m_busy) begin
        if (m_cnt == CORE_LAT) begin
          m_x <= core_x_in + 32'd1;
          m_y <= core_y_in + 32'd2;
          m_z <= core_z_in + 32'd3;
        end
        if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign core_valid = m_valid | man_valid;
  assign core_x_out = man_valid ? man_x : m_x;
  assign core_y_out = man_valid ? man_y : m_y;
  assign core_z_out = man_valid ? man_z : m_z;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] one = 4'b0001;
    return one << i;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [1:0] coord,
                         input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    req_mode_op[2*i +: 2]    = op;
    req_mode_coord[2*i +: 2] = coord;
    req_x[W*i +: W] = x;
    req_y[W*i +: W] = y;
    req_z[W*i +: W] = z;
  endtask

  // Called in ISSUE: waits for the response, checks it, completes handshake.
  task automatic finish_op(input string tag, input int g,
                           input logic [W-1:0] ex, input logic [W-1:0] ey, input logic [W-1:0] ez);
    int t = 0;
    while (rsp_valid == '0 && t < 200) begin tick(); t++; end
    check({tag, "_rsp_valid"}, rsp_valid, oh(g));
    check({tag, "_rsp_x"}, rsp_x, ex);
    check({tag, "_rsp_y"}, rsp_y, ey);
    check({tag, "_rsp_z"}, rsp_z, ez);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    rsp_ready = oh(g);
    tick();
    rsp_ready = '0;
  endtask

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [1:0] coord;
    logic [W-1:0] x, y, z;
    logic [W-1:0] ex, ey, ez;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t v;
    int   t;
    int   rr_order[8];
    logic [W-1:0] rr_x[4], rr_y[4], rr_z[4];
    logic [W-1:0] rr_ex[4], rr_ey[4], rr_ez[4];

    // idx, op, coord, x, y, z, expected x+1, y+2, z+3
    vecs[0] = '{2, MODE_OP_ROTATION,  MODE_COORD_CIRCULAR,   32'h4000_0000, 32'h0000_0000, 32'h2000_0000,
                32'h4000_0001, 32'h0000_0002, 32'h2000_0003};
    vecs[1] = '{0, MODE_OP_VECTORING, MODE_COORD_LINEAR,     32'h0000_1000, 32'hFFFF_F000, 32'h0000_0000,
                32'h0000_1001, 32'hFFFF_F002, 32'h0000_0003};
    vecs[2] = '{3, MODE_OP_ROTATION,  MODE_COORD_HYPERBOLIC, 32'h7FFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFE,
                32'h8000_0000, 32'h1234_567A, 32'h0000_0001};
    vecs[3] = '{1, MODE_OP_VECTORING, MODE_COORD_CIRCULAR,   32'hDEAD_BEEF, 32'h0000_FFFE, 32'h0000_0010,
                32'hDEAD_BEF0, 32'h0001_0000, 32'h0000_0013};

    rr_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    rr_x  = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
    rr_y  = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040};
    rr_z  = '{32'hFFFF_FFF0, 32'hFFFF_FFF1, 32'hFFFF_FFF2, 32'hFFFF_FFF3};
    rr_ex = '{32'h1000_0001, 32'h2000_0001, 32'h3000_0001, 32'h4000_0001};
    rr_ey = '{32'h0000_0012, 32'h0000_0022, 32'h0000_0032, 32'h0000_0042};
    rr_ez = '{32'hFFFF_FFF3, 32'hFFFF_FFF4, 32'hFFFF_FFF5, 32'hFFFF_FFF6};

    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    req_mode_op = '0; req_mode_coord = '0; req_x = '0; req_y = '0; req_z = '0;
    tick(); tick();

    // ---- reset state ----
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_core_enable", core_enable, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rel_core_rst", core_rst, 1'b0);

    // ---- all four requesting: round-robin order 0,1,2,3,0,1,2,3 ----
    for (int i = 0; i < NR; i++)
      set_req(i, MODE_OP_ROTATION, MODE_COORD_CIRCULAR, rr_x[i], rr_y[i], rr_z[i]);
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #1;
    for (int op = 0; op < 8; op++) begin
      t = 0;
      while (req_ready == '0 && t < 100) begin tick(); t++; end
      check("rr_grant", req_ready, oh(rr_order[op]));
      check("rr_gap", t, 0);
      tick();
      t = 0;
      while (rsp_valid == '0 && t < 200) begin tick(); t++; end
      check("rr_rsp_valid", rsp_valid, oh(rr_order[op]));
      check("rr_rsp_x", rsp_x, rr_ex[rr_order[op]]);
      check("rr_rsp_y", rsp_y, rr_ey[rr_order[op]]);
      check("rr_rsp_z", rsp_z, rr_ez[rr_order[op]]);
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;
    tick();

    // ---- table vectors: single requests ----
    for (int n = 0; n < 4; n++) begin
      v = vecs[n];
      set_req(v.idx, v.op, v.coord, v.x, v.y, v.z);
      req_valid = oh(v.idx);
      #1;
      check("t_req_ready", req_ready, oh(v.idx));
      check("t_en_accept", core_enable, 1'b0);
      tick();
      req_valid = '0;
      check("t_enable", core_enable, 1'b1);
      check("t_ready_once", req_ready, '0);
      check("t_mode_op", core_mode_op, v.op);
      check("t_mode_coord", core_mode_coord, v.coord);
      check("t_x_in", core_x_in, v.x);
      check("t_y_in", core_y_in, v.y);
      check("t_z_in", core_z_in, v.z);
      tick();
      check("t_en_once", core_enable, 1'b0);
      check("t_x_hold", core_x_in, v.x);
      check("t_z_hold", core_z_in, v.z);
      t = 0;
      while (!core_valid && t < 200) begin tick(); t++; end
      check("t_core_valid", core_valid, 1'b1);
      check("t_rsp_not_yet", rsp_valid, '0);
      tick();
      check("t_rsp_valid", rsp_valid, oh(v.idx));
      check("t_rsp_x", rsp_x, v.ex);
      check("t_rsp_y", rsp_y, v.ey);
      check("t_rsp_z", rsp_z, v.ez);
      check("t_rsp_err", rsp_err, 1'b0);
      rsp_ready = oh(v.idx);
      tick();
      rsp_ready = '0;
      check("t_rsp_clear", rsp_valid, '0);
    end

    // ---- response backpressure (last grant 1 -> requester 0 wins) ----
    set_req(0, MODE_OP_ROTATION, MODE_COORD_LINEAR, 32'h0BAD_0000, 32'h0000_0100, 32'h7FFF_FFFD);
    set_req(1, MODE_OP_VECTORING, MODE_COORD_HYPERBOLIC, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    req_valid = 4'b0011;
    #1;
    check("bp_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    t = 0;
    while (rsp_valid == '0 && t < 200) begin tick(); t++; end
    rsp_ready = 4'b0010;  // non-owner ready must be ignored
    for (int c = 0; c < 20; c++) begin
      check("bp_rsp_valid", rsp_valid, 4'b0001);
      check("bp_rsp_x", rsp_x, 32'h0BAD_0001);
      check("bp_rsp_z", rsp_z, 32'h8000_0000);
      check("bp_no_ready", req_ready, '0);
      check("bp_no_enable", core_enable, 1'b0);
      tick();
    end
    check("bp_rsp_y", rsp_y, 32'h0000_0102);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    check("bp_idle_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    finish_op("bp2", 1, 32'h1111_1112, 32'h2222_2224, 32'h3333_3336);

    // ---- reset during WAIT ----
    set_req(2, MODE_OP_ROTATION, MODE_COORD_CIRCULAR, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777);
    req_valid = 4'b0100;
    #1;
    check("rw_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    check("rw_in_wait", core_x_in, 32'h5555_5555);
    set_req(0, MODE_OP_VECTORING, MODE_COORD_LINEAR, 32'h0000_0005, 32'h0000_0006, 32'h0000_0007);
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    check("rw_core_rst", core_rst, 1'b1);
    check("rw_req_ready", req_ready, '0);
    check("rw_x_in", core_x_in, '0);
    check("rw_mode_op", core_mode_op, '0);
    check("rw_rsp_x", rsp_x, '0);
    tick();
    check("rw_core_rst_hold", core_rst, 1'b1);
    check("rw_enable", core_enable, 1'b0);
    check("rw_rsp_valid", rsp_valid, '0);
    rst_n = 1'b1;
    #1;
    check("rw_rst_release", core_rst, 1'b0);
    check("rw_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    finish_op("rw", 0, 32'h0000_0006, 32'h0000_0008, 32'h0000_000A);

    // ---- watchdog: core never answers ----
    core_mute = 1'b1;
    set_req(1, MODE_OP_ROTATION, MODE_COORD_CIRCULAR, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
    req_valid = 4'b0010;
    #1;
    check("to_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();  // first WAIT cycle
`ifdef CORDIC_ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      check("to_core_rst_low", core_rst, 1'b0);
      tick();
    end
    check("to_core_rst_pulse", core_rst, 1'b1);
    check("to_no_rsp_yet", rsp_valid, '0);
    tick();
    check("to_core_rst_once", core_rst, 1'b0);
    check("to_rsp_valid", rsp_valid, 4'b0010);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_x", rsp_x, '0);
    check("to_rsp_y", rsp_y, '0);
    check("to_rsp_z", rsp_z, '0);
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
`else
    for (int k = 0; k < 40; k++) begin
      check("to_still_wait", rsp_valid, '0);
      check("to_no_core_rst", core_rst, 1'b0);
      tick();
    end
    man_x = 32'hCAFE_0001; man_y = 32'hCAFE_0002; man_z = 32'hCAFE_0003;
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    finish_op("to_late", 1, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
`endif

    // ---- core_valid in the expiry cycle wins ----
    set_req(3, MODE_OP_VECTORING, MODE_COORD_CIRCULAR, 32'h0000_0009, 32'h0000_0008, 32'h0000_0007);
    req_valid = 4'b1000;
    #1;
    check("sc_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();  // first WAIT cycle
    for (int k = 0; k < TO; k++) tick();
    man_x = 32'hA5A5_A5A5; man_y = 32'h5A5A_5A5A; man_z = 32'h0F0F_0F0F;
    man_valid = 1'b1;
    #1;
    check("sc_no_core_rst", core_rst, 1'b0);
    tick();
    man_valid = 1'b0;
    finish_op("sc", 3, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0F0F_0F0F);
    core_mute = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin scheduler that shares one `cordic` core among `NUM_REQ` independent requesters. It accepts one operation at a time from the granted requester and latches that requester's mode and operands. It then issues the operation to the core, waits for the core's `valid` pulse and returns the result to the owning requester through a per-requester valid/ready response. It sits between the core and the client blocks (function generator, vector-magnitude unit and similar), so no client ever drives the core directly.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `WIDTH`, 32: operand/result width; must match the core.
- `TIMEOUT`, 1023: watchdog limit in cycles (used only with `CORDIC_ARB_TIMEOUT_EN`).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot acceptance pulse.
- `req_mode_op`  in  2*NUM_REQ  mode_op per requester, slice i at [2i+1:2i].
- `req_mode_coord`  in  2*NUM_REQ  mode_coord per requester.
- `req_x`, `req_y`, `req_z`  in  WIDTH*NUM_REQ  operands per requester.
- `rsp_valid`  out  NUM_REQ  one-hot result valid.
- `rsp_ready`  in  NUM_REQ  per-requester result ready.
- `rsp_x`, `rsp_y`, `rsp_z`  out  WIDTH  shared result bus.
- `rsp_err`  out  1  result aborted by watchdog.
- `core_enable`  out  1  start pulse to the core.
- `core_rst`  out  1  active-high reset to the core.
- `core_mode_op`, `core_mode_coord`  out  2  latched modes.
- `core_x_in`, `core_y_in`, `core_z_in`  out  WIDTH  latched operands.
- `core_x_out`, `core_y_out`, `core_z_out`  in  WIDTH  core results.
- `core_valid`  in  1  core done pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: if any `req_valid` is set, grant the first set bit searching from `last_grant+1` modulo NUM_REQ. In the same cycle:
  - pulse `req_ready[g]`;
  - latch modes and operands;
  - set `last_grant <= g`;
  - go to ISSUE.
- ISSUE: `core_enable=1` for exactly one cycle, then go to WAIT.
- WAIT: on `core_valid`, latch `core_*_out` into `rsp_*`, set `rsp_err=0`, go to RESPOND.
- RESPOND: `rsp_valid[g]=1`, with data held stable, until `rsp_ready[g]`; that cycle returns to IDLE.
- `core_*_in` and `core_mode_*` are driven from the latch continuously from ISSUE through WAIT. This is required because the core samples operands one cycle after `enable`.
- Requesters hold `req_valid` and data stable until `req_ready`. Dropping `req_valid` early is legal; such a request is simply not granted.
- `rsp_ready` on a non-owner index is ignored. `core_valid` outside WAIT is ignored.
- Reset values: FSM IDLE, `last_grant=NUM_REQ-1` (so requester 0 wins first), all outputs 0.
- Reset mid-operation discards the in-flight op. `core_rst` is driven 1 while `rst_n=0` (combinational), so the core restarts too.

## Timing
- Accept to `core_enable`: 1 cycle.
- `core_valid` to `rsp_valid`: 1 cycle.
- Total latency is core latency + 2 cycles.
- Minimum gap between grants is 1 IDLE cycle after the response handshake.
- With all requesters continuously requesting, the grant order is 0,1,2,3,0,...

## Configuration
- `CORDIC_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - When it reaches TIMEOUT without `core_valid`: pulse `core_rst` for one cycle, set `rsp_*=0` and `rsp_err=1`, go to RESPOND.
  - The counter clears on entry to WAIT.
  - `core_valid` in the same cycle as expiry wins: normal result, `rsp_err=0`.
- Not defined: no counter; WAIT lasts until `core_valid`; `rsp_err` is constant 0; `core_rst` follows reset only.

## Structure
- Shared package `cordic_pkg` holds:
  - mode encodings (CIRCULAR=01, LINEAR=00, HYPERBOLIC=11, ROTATION=00, VECTORING=01);
  - the arbiter state enum;
  - the default WIDTH.
- One sub-module, `rr_pick`: combinational round-robin picker with inputs req vector and last grant, outputs one-hot grant and index.

## Test plan
- Single request: req 2 with x=0x4000_0000, y=0, z=0x2000_0000 (45°), circular rotation.
  - `req_ready[2]` pulses in the accept cycle.
  - `core_enable` fires 1 cycle later.
  - Results are captured 1 cycle after `core_valid`.
  - `rsp_valid=4'b0100` until `rsp_ready[2]`.
- All four requesters asserted for 8 ops (bench core model with 35-cycle latency, returning x+1, y+2, z+3) -> grant order 0,1,2,3,0,1,2,3; each response matches its own operands +1/+2/+3.
- Response backpressure: `rsp_ready` held low for 20 cycles -> `rsp_*` stable, no new `req_ready`, `core_enable` not reasserted.
- `rst_n` pulled low during WAIT -> all outputs 0 next cycle, `core_rst=1` while low, first grant after release goes to requester 0.
- Timeout (macro on, TIMEOUT=15, core never valid) -> `core_rst` pulses 15 cycles after entering WAIT, then `rsp_err=1` with `rsp_*=0`. Macro off -> FSM stays in WAIT indefinitely.
- `core_valid` on the same cycle as timeout expiry -> `rsp_err=0` and the core data is returned.
